// File: rtl/decode_pipe.sv
// RV32I/RV32E decode stage: register file, instruction decoder
// and the ID/EX pipeline register with stall, flush and bubble.
module decode_pipe #(
    parameter int XLEN   = 32,
    parameter int NREGS  = 32,
    parameter int BYPASS = 1
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            regwriteW,
    input  logic [4:0]      rdW,
    input  logic [XLEN-1:0] resultW,
    input  logic            validD,
    input  logic [31:0]     instrD,
    input  logic [XLEN-1:0] pcD,
    input  logic [XLEN-1:0] pc4D,
    input  logic            stallE,
    input  logic            flushE,
    output logic [4:0]      rs1D,
    output logic [4:0]      rs2D,
    output logic            loaduse_hazard,
    output logic            validE,
    output logic            regwriteE,
    output logic            memrwE,
    output logic            memreadE,
    output logic            brunE,
    output logic            branchE,
    output logic            jumpE,
    output logic            jalrE,
    output logic            bselE,
    output logic            aselE,
    output logic            illegalE,
    output logic [1:0]      wbselE,
    output logic [2:0]      funct3E,
    output logic [3:0]      aluselE,
    output logic [4:0]      rdE,
    output logic [4:0]      rs1E,
    output logic [4:0]      rs2E,
    output logic [XLEN-1:0] rd1E,
    output logic [XLEN-1:0] rd2E,
    output logic [XLEN-1:0] imm_exE,
    output logic [XLEN-1:0] pcE,
    output logic [XLEN-1:0] pc4E
);
    localparam int         AW = $clog2(NREGS);
    localparam logic [5:0] NR = 6'(NREGS);

    localparam logic [6:0] OP_R    = 7'b0110011;
    localparam logic [6:0] OP_I    = 7'b0010011;
    localparam logic [6:0] OP_LD   = 7'b0000011;
    localparam logic [6:0] OP_ST   = 7'b0100011;
    localparam logic [6:0] OP_BR   = 7'b1100011;
    localparam logic [6:0] OP_JAL  = 7'b1101111;
    localparam logic [6:0] OP_JALR = 7'b1100111;
    localparam logic [6:0] OP_LUI  = 7'b0110111;
    localparam logic [6:0] OP_AUI  = 7'b0010111;

    localparam logic [3:0] A_ADD  = 4'd0;
    localparam logic [3:0] A_SUB  = 4'd1;
    localparam logic [3:0] A_AND  = 4'd2;
    localparam logic [3:0] A_OR   = 4'd3;
    localparam logic [3:0] A_XOR  = 4'd4;
    localparam logic [3:0] A_SLL  = 4'd5;
    localparam logic [3:0] A_SRL  = 4'd6;
    localparam logic [3:0] A_SRA  = 4'd7;
    localparam logic [3:0] A_SLT  = 4'd8;
    localparam logic [3:0] A_SLTU = 4'd9;
    localparam logic [3:0] A_B    = 4'd10;

    typedef struct packed {
        logic            valid;
        logic            regwrite;
        logic            memrw;
        logic            memread;
        logic            brun;
        logic            branch;
        logic            jump;
        logic            jalr;
        logic            bsel;
        logic            asel;
        logic            illegal;
        logic [1:0]      wbsel;
        logic [2:0]      funct3;
        logic [3:0]      alusel;
        logic [4:0]      rd;
        logic [4:0]      rs1;
        logic [4:0]      rs2;
        logic [XLEN-1:0] rd1;
        logic [XLEN-1:0] rd2;
        logic [XLEN-1:0] imm;
        logic [XLEN-1:0] pc;
        logic [XLEN-1:0] pc4;
    } idex_t;

    idex_t           d;
    idex_t           q;
    logic [XLEN-1:0] regs [NREGS];
    logic [XLEN-1:0] rd1;
    logic [XLEN-1:0] rd2;
    logic            use_rd;
    logic            use1;
    logic            use2;
    logic            bad;
    logic [6:0]      op;
    logic [6:0]      f7;
    logic [2:0]      f3;
    logic [4:0]      rdf;
    logic [XLEN-1:0] imm_i;
    logic [XLEN-1:0] imm_s;
    logic [XLEN-1:0] imm_b;
    logic [XLEN-1:0] imm_j;
    logic [XLEN-1:0] imm_u;

    assign op   = instrD[6:0];
    assign rdf  = instrD[11:7];
    assign f3   = instrD[14:12];
    assign rs1D = instrD[19:15];
    assign rs2D = instrD[24:20];
    assign f7   = instrD[31:25];

    assign imm_i = {{(XLEN-12){instrD[31]}}, instrD[31:20]};
    assign imm_s = {{(XLEN-12){instrD[31]}}, instrD[31:25], instrD[11:7]};
    assign imm_b = {{(XLEN-13){instrD[31]}}, instrD[31], instrD[7],
                    instrD[30:25], instrD[11:8], 1'b0};
    assign imm_j = {{(XLEN-21){instrD[31]}}, instrD[31], instrD[19:12],
                    instrD[20], instrD[30:21], 1'b0};
    assign imm_u = XLEN'({instrD[31:12], 12'b0});

    // Register file: cleared by reset, x0 and out-of-range writes dropped
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < NREGS; i++) regs[i] <= '0;
        end else if (regwriteW && rdW != 5'd0 && {1'b0, rdW} < NR) begin
            regs[rdW[AW-1:0]] <= resultW;
        end
    end

    // Read ports with optional same-cycle forwarding of write-back data
    always_comb begin
        rd1 = '0;
        rd2 = '0;
        if (rs1D != 5'd0 && {1'b0, rs1D} < NR) begin
            rd1 = regs[rs1D[AW-1:0]];
            if (BYPASS != 0 && regwriteW && rdW == rs1D) rd1 = resultW;
        end
        if (rs2D != 5'd0 && {1'b0, rs2D} < NR) begin
            rd2 = regs[rs2D[AW-1:0]];
            if (BYPASS != 0 && regwriteW && rdW == rs2D) rd2 = resultW;
        end
    end

    // Instruction decode into the next ID/EX bundle
    always_comb begin
        d        = '0;
        use_rd   = 1'b0;
        use1     = 1'b0;
        use2     = 1'b0;
        bad      = 1'b0;
        d.valid  = 1'b1;
        d.funct3 = f3;
        d.rd     = rdf;
        d.rs1    = rs1D;
        d.rs2    = rs2D;
        d.rd1    = rd1;
        d.rd2    = rd2;
        d.pc     = pcD;
        d.pc4    = pc4D;
        unique case (op)
            OP_R: begin
                use_rd     = 1'b1;
                use1       = 1'b1;
                use2       = 1'b1;
                d.regwrite = 1'b1;
                d.wbsel    = 2'b01;
                unique case ({f7, f3})
                    {7'h00, 3'd0}: d.alusel = A_ADD;
                    {7'h20, 3'd0}: d.alusel = A_SUB;
                    {7'h00, 3'd1}: d.alusel = A_SLL;
                    {7'h00, 3'd2}: d.alusel = A_SLT;
                    {7'h00, 3'd3}: d.alusel = A_SLTU;
                    {7'h00, 3'd4}: d.alusel = A_XOR;
                    {7'h00, 3'd5}: d.alusel = A_SRL;
                    {7'h20, 3'd5}: d.alusel = A_SRA;
                    {7'h00, 3'd6}: d.alusel = A_OR;
                    {7'h00, 3'd7}: d.alusel = A_AND;
                    default:       bad      = 1'b1;
                endcase
            end
            OP_I: begin
                use_rd     = 1'b1;
                use1       = 1'b1;
                d.regwrite = 1'b1;
                d.wbsel    = 2'b01;
                d.bsel     = 1'b1;
                d.imm      = imm_i;
                unique case (f3)
                    3'd0: d.alusel = A_ADD;
                    3'd2: d.alusel = A_SLT;
                    3'd3: d.alusel = A_SLTU;
                    3'd4: d.alusel = A_XOR;
                    3'd6: d.alusel = A_OR;
                    3'd7: d.alusel = A_AND;
                    3'd1: begin
                        if (f7 == 7'h00) d.alusel = A_SLL;
                        else bad = 1'b1;
                    end
                    3'd5: begin
                        if (f7 == 7'h00 || f7 == 7'h20)
                            d.alusel = instrD[30] ? A_SRA : A_SRL;
                        else bad = 1'b1;
                    end
                endcase
            end
            OP_LD: begin
                use_rd     = 1'b1;
                use1       = 1'b1;
                d.regwrite = 1'b1;
                d.memread  = 1'b1;
                d.bsel     = 1'b1;
                d.imm      = imm_i;
                if (f3 == 3'd3 || f3[2:1] == 2'b11) bad = 1'b1;
            end
            OP_ST: begin
                use1    = 1'b1;
                use2    = 1'b1;
                d.memrw = 1'b1;
                d.bsel  = 1'b1;
                d.imm   = imm_s;
                if (f3[2] || f3[1:0] == 2'b11) bad = 1'b1;
            end
            OP_BR: begin
                use1     = 1'b1;
                use2     = 1'b1;
                d.branch = 1'b1;
                d.asel   = 1'b1;
                d.bsel   = 1'b1;
                d.brun   = f3[2] & f3[1];
                d.imm    = imm_b;
                if (f3[2:1] == 2'b01) bad = 1'b1;
            end
            OP_JAL: begin
                use_rd     = 1'b1;
                d.regwrite = 1'b1;
                d.jump     = 1'b1;
                d.asel     = 1'b1;
                d.bsel     = 1'b1;
                d.wbsel    = 2'b10;
                d.imm      = imm_j;
            end
            OP_JALR: begin
                use_rd     = 1'b1;
                use1       = 1'b1;
                d.regwrite = 1'b1;
                d.jump     = 1'b1;
                d.jalr     = 1'b1;
                d.bsel     = 1'b1;
                d.wbsel    = 2'b10;
                d.imm      = imm_i;
                if (f3 != 3'd0) bad = 1'b1;
            end
            OP_LUI: begin
                use_rd     = 1'b1;
                d.regwrite = 1'b1;
                d.wbsel    = 2'b01;
                d.bsel     = 1'b1;
                d.alusel   = A_B;
                d.imm      = imm_u;
            end
            OP_AUI: begin
                use_rd     = 1'b1;
                d.regwrite = 1'b1;
                d.wbsel    = 2'b01;
                d.asel     = 1'b1;
                d.bsel     = 1'b1;
                d.imm      = imm_u;
            end
            default: bad = 1'b1;
        endcase
        if ((use_rd && {1'b0, rdf} >= NR) ||
            (use1 && {1'b0, rs1D} >= NR) ||
            (use2 && {1'b0, rs2D} >= NR)) bad = 1'b1;
        if (bad) begin
            d.illegal  = 1'b1;
            d.regwrite = 1'b0;
            d.memrw    = 1'b0;
            d.memread  = 1'b0;
            d.branch   = 1'b0;
            d.jump     = 1'b0;
            d.jalr     = 1'b0;
            d.brun     = 1'b0;
        end
    end

    // ID/EX register: reset, then flush, then stall hold, then load
    always_ff @(posedge clk) begin
        if (rst || flushE) q <= '0;
        else if (!stallE) q <= validD ? d : '0;
    end

    assign loaduse_hazard = q.memread && q.rd != 5'd0 && validD &&
                            ((use1 && q.rd == rs1D) ||
                             (use2 && q.rd == rs2D));

    assign validE    = q.valid;
    assign regwriteE = q.regwrite;
    assign memrwE    = q.memrw;
    assign memreadE  = q.memread;
    assign brunE     = q.brun;
    assign branchE   = q.branch;
    assign jumpE     = q.jump;
    assign jalrE     = q.jalr;
    assign bselE     = q.bsel;
    assign aselE     = q.asel;
    assign illegalE  = q.illegal;
    assign wbselE    = q.wbsel;
    assign funct3E   = q.funct3;
    assign aluselE   = q.alusel;
    assign rdE       = q.rd;
    assign rs1E      = q.rs1;
    assign rs2E      = q.rs2;
    assign rd1E      = q.rd1;
    assign rd2E      = q.rd2;
    assign imm_exE   = q.imm;
    assign pcE       = q.pc;
    assign pc4E      = q.pc4;
endmodule

// File: tb/tb_decode_pipe.sv
// Bench for decode_pipe: directed scenarios then random instruction
// streams checked against a mask/match instruction-table model.
module tb_decode_pipe;
    logic        clk = 1'b0;
    logic        rst, regwriteW, validD, stallE, flushE;
    logic [4:0]  rdW;
    logic [31:0] resultW, instrD, pcD, pc4D;

    logic [4:0]  rs1D, rs2D, rdE, rs1E, rs2E;
    logic        loaduse_hazard, validE, regwriteE, memrwE, memreadE;
    logic        brunE, branchE, jumpE, jalrE, bselE, aselE, illegalE;
    logic [1:0]  wbselE;
    logic [2:0]  funct3E;
    logic [3:0]  aluselE;
    logic [31:0] rd1E, rd2E, imm_exE, pcE, pc4E;

    logic [4:0]  b_rs1D, b_rs2D, b_rdE, b_rs1E, b_rs2E;
    logic        b_lu, b_validE, b_regwriteE, b_memrwE, b_memreadE;
    logic        b_brunE, b_branchE, b_jumpE, b_jalrE, b_bselE, b_aselE;
    logic        b_illegalE;
    logic [1:0]  b_wbselE;
    logic [2:0]  b_funct3E;
    logic [3:0]  b_aluselE;
    logic [31:0] b_rd1E, b_rd2E, b_imm_exE, b_pcE, b_pc4E;

    always #5 clk = ~clk;

    decode_pipe #(.XLEN(32), .NREGS(32), .BYPASS(1)) dut (
        .clk(clk), .rst(rst), .regwriteW(regwriteW), .rdW(rdW),
        .resultW(resultW), .validD(validD), .instrD(instrD), .pcD(pcD),
        .pc4D(pc4D), .stallE(stallE), .flushE(flushE), .rs1D(rs1D),
        .rs2D(rs2D), .loaduse_hazard(loaduse_hazard), .validE(validE),
        .regwriteE(regwriteE), .memrwE(memrwE), .memreadE(memreadE),
        .brunE(brunE), .branchE(branchE), .jumpE(jumpE), .jalrE(jalrE),
        .bselE(bselE), .aselE(aselE), .illegalE(illegalE),
        .wbselE(wbselE), .funct3E(funct3E), .aluselE(aluselE),
        .rdE(rdE), .rs1E(rs1E), .rs2E(rs2E), .rd1E(rd1E), .rd2E(rd2E),
        .imm_exE(imm_exE), .pcE(pcE), .pc4E(pc4E)
    );

    decode_pipe #(.XLEN(32), .NREGS(16), .BYPASS(1)) dut_e (
        .clk(clk), .rst(rst), .regwriteW(regwriteW), .rdW(rdW),
        .resultW(resultW), .validD(validD), .instrD(instrD), .pcD(pcD),
        .pc4D(pc4D), .stallE(stallE), .flushE(flushE), .rs1D(b_rs1D),
        .rs2D(b_rs2D), .loaduse_hazard(b_lu), .validE(b_validE),
        .regwriteE(b_regwriteE), .memrwE(b_memrwE),
        .memreadE(b_memreadE), .brunE(b_brunE), .branchE(b_branchE),
        .jumpE(b_jumpE), .jalrE(b_jalrE), .bselE(b_bselE),
        .aselE(b_aselE), .illegalE(b_illegalE), .wbselE(b_wbselE),
        .funct3E(b_funct3E), .aluselE(b_aluselE), .rdE(b_rdE),
        .rs1E(b_rs1E), .rs2E(b_rs2E), .rd1E(b_rd1E), .rd2E(b_rd2E),
        .imm_exE(b_imm_exE), .pcE(b_pcE), .pc4E(b_pc4E)
    );

    localparam int C_NONE = 0, C_R = 1, C_I = 2, C_LD = 3, C_ST = 4;
    localparam int C_BR = 5, C_JAL = 6, C_JALR = 7, C_LUI = 8;
    localparam int C_AUI = 9, C_BAD = 10;
    localparam logic [31:0] MR = 32'hFE00707F;
    localparam logic [31:0] MF = 32'h0000707F;
    localparam logic [31:0] MO = 32'h0000007F;
    localparam int NT = 37;

    typedef struct {
        logic [31:0] mask;
        logic [31:0] match;
        int          cls;
        logic [3:0]  alu;
    } ent_t;

    typedef struct {
        int          cls;
        logic [3:0]  alu;
        logic [2:0]  f3;
        logic [4:0]  rd, rs1, rs2;
        logic [31:0] rd1, rd2, imm, pc, pc4;
    } exp_t;

    ent_t tbl [NT] = '{
        '{MR, 32'h00000033, C_R, 4'd0},  '{MR, 32'h40000033, C_R, 4'd1},
        '{MR, 32'h00001033, C_R, 4'd5},  '{MR, 32'h00002033, C_R, 4'd8},
        '{MR, 32'h00003033, C_R, 4'd9},  '{MR, 32'h00004033, C_R, 4'd4},
        '{MR, 32'h00005033, C_R, 4'd6},  '{MR, 32'h40005033, C_R, 4'd7},
        '{MR, 32'h00006033, C_R, 4'd3},  '{MR, 32'h00007033, C_R, 4'd2},
        '{MF, 32'h00000013, C_I, 4'd0},  '{MF, 32'h00002013, C_I, 4'd8},
        '{MF, 32'h00003013, C_I, 4'd9},  '{MF, 32'h00004013, C_I, 4'd4},
        '{MF, 32'h00006013, C_I, 4'd3},  '{MF, 32'h00007013, C_I, 4'd2},
        '{MR, 32'h00001013, C_I, 4'd5},  '{MR, 32'h00005013, C_I, 4'd6},
        '{MR, 32'h40005013, C_I, 4'd7},
        '{MF, 32'h00000003, C_LD, 4'd0}, '{MF, 32'h00001003, C_LD, 4'd0},
        '{MF, 32'h00002003, C_LD, 4'd0}, '{MF, 32'h00004003, C_LD, 4'd0},
        '{MF, 32'h00005003, C_LD, 4'd0},
        '{MF, 32'h00000023, C_ST, 4'd0}, '{MF, 32'h00001023, C_ST, 4'd0},
        '{MF, 32'h00002023, C_ST, 4'd0},
        '{MF, 32'h00000063, C_BR, 4'd0}, '{MF, 32'h00001063, C_BR, 4'd0},
        '{MF, 32'h00004063, C_BR, 4'd0}, '{MF, 32'h00005063, C_BR, 4'd0},
        '{MF, 32'h00006063, C_BR, 4'd0}, '{MF, 32'h00007063, C_BR, 4'd0},
        '{MF, 32'h00000067, C_JALR, 4'd0},
        '{MO, 32'h0000006F, C_JAL, 4'd0},
        '{MO, 32'h00000037, C_LUI, 4'd10},
        '{MO, 32'h00000017, C_AUI, 4'd0}
    };

    logic [31:0] rf [32];
    exp_t        exp_q;
    int          total = 0;
    int          bad = 0;

    function automatic bit u1(input int c);
        return c inside {C_R, C_I, C_LD, C_ST, C_BR, C_JALR};
    endfunction

    function automatic bit u2(input int c);
        return c inside {C_R, C_ST, C_BR};
    endfunction

    function automatic bit wr(input int c);
        return c inside {C_R, C_I, C_LD, C_JAL, C_JALR, C_LUI, C_AUI};
    endfunction

    function automatic logic [31:0] rf_read(input logic [4:0] r);
        if (r == 5'd0) return 32'd0;
        if (regwriteW && rdW == r) return resultW;
        return rf[r];
    endfunction

    function automatic exp_t model(input logic [31:0] ins);
        exp_t        e;
        logic [12:0] b;
        logic [20:0] j;
        e = '{default: 0};
        e.cls = C_BAD;
        for (int k = 0; k < NT; k++)
            if ((ins & tbl[k].mask) == tbl[k].match) begin
                e.cls = tbl[k].cls;
                e.alu = tbl[k].alu;
            end
        e.f3  = ins[14:12];
        e.rd  = ins[11:7];
        e.rs1 = ins[19:15];
        e.rs2 = ins[24:20];
        e.rd1 = rf_read(e.rs1);
        e.rd2 = rf_read(e.rs2);
        e.pc  = pcD;
        e.pc4 = pc4D;
        b = {ins[31], ins[7], ins[30:25], ins[11:8], 1'b0};
        j = {ins[31], ins[19:12], ins[20], ins[30:21], 1'b0};
        case (e.cls)
            C_I, C_LD, C_JALR: e.imm = 32'($signed(ins[31:20]));
            C_ST:  e.imm = 32'($signed({ins[31:25], ins[11:7]}));
            C_BR:  e.imm = 32'($signed(b));
            C_JAL: e.imm = 32'($signed(j));
            C_LUI, C_AUI: e.imm = ins & 32'hFFFFF000;
            default: e.imm = 32'd0;
        endcase
        return e;
    endfunction

    task automatic chk(input string tag, input logic [255:0] obs,
                       input logic [255:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic cmp_all(input string tag);
        int c;
        c = exp_q.cls;
        if (c == C_NONE) begin
            chk({tag, ".bubble"},
                {validE, regwriteE, memrwE, memreadE, brunE, branchE,
                 jumpE, jalrE, bselE, aselE, illegalE, wbselE, funct3E,
                 aluselE, rdE, rs1E, rs2E, rd1E, rd2E, imm_exE, pcE,
                 pc4E}, '0);
        end else if (c == C_BAD) begin
            chk({tag, ".illegal"},
                {validE, illegalE, regwriteE, memrwE, memreadE,
                 branchE, jumpE}, 7'b1100000);
        end else begin
            chk({tag, ".ctl"},
                {validE, illegalE, regwriteE, memrwE, memreadE, branchE,
                 jumpE, jalrE, brunE},
                {1'b1, 1'b0, wr(c), c == C_ST, c == C_LD, c == C_BR,
                 c == C_JAL || c == C_JALR, c == C_JALR,
                 c == C_BR && exp_q.f3[2:1] == 2'b11});
            chk({tag, ".pc"}, {pcE, pc4E}, {exp_q.pc, exp_q.pc4});
            if (c == C_LD) chk({tag, ".wbsel"}, wbselE, 2'b00);
            else if (c == C_JAL || c == C_JALR)
                chk({tag, ".wbsel"}, wbselE, 2'b10);
            else if (wr(c)) chk({tag, ".wbsel"}, wbselE, 2'b01);
            if (c inside {C_BR, C_LUI, C_AUI})
                chk({tag, ".bsel"}, bselE, 1'b1);
            if (c == C_AUI) chk({tag, ".asel"}, aselE, 1'b1);
            if (c inside {C_R, C_I, C_LUI, C_AUI})
                chk({tag, ".alu"}, aluselE, exp_q.alu);
            if (c != C_R) chk({tag, ".imm"}, imm_exE, exp_q.imm);
            if (u1(c)) chk({tag, ".rs1"}, {rs1E, rd1E},
                           {exp_q.rs1, exp_q.rd1});
            if (u2(c)) chk({tag, ".rs2"}, {rs2E, rd2E},
                           {exp_q.rs2, exp_q.rd2});
            if (wr(c)) chk({tag, ".rd"}, rdE, exp_q.rd);
            if (c inside {C_R, C_I, C_LD, C_ST, C_BR})
                chk({tag, ".f3"}, funct3E, exp_q.f3);
        end
    endtask

    task automatic set_in(input logic v, input logic [31:0] ins,
                          input logic rw, input logic [4:0] rd,
                          input logic [31:0] res, input logic st,
                          input logic fl, input logic [31:0] pc);
        validD = v; instrD = ins; regwriteW = rw; rdW = rd;
        resultW = res; stallE = st; flushE = fl;
        pcD = pc; pc4D = pc + 32'd4;
    endtask

    // One clock: check combinational outputs, advance the model, check ID/EX
    task automatic step(input string tag);
        exp_t cur;
        bit   lu;
        #1;
        cur = model(instrD);
        chk({tag, ".rsD"}, {rs1D, rs2D}, {instrD[19:15], instrD[24:20]});
        lu = validD && exp_q.cls == C_LD && exp_q.rd != 5'd0 &&
             ((u1(cur.cls) && exp_q.rd == cur.rs1) ||
              (u2(cur.cls) && exp_q.rd == cur.rs2));
        if (!rst && (!validD || cur.cls != C_BAD))
            chk({tag, ".loaduse"}, loaduse_hazard, lu);
        if (rst) begin
            exp_q = '{default: 0};
            for (int i = 0; i < 32; i++) rf[i] = 32'd0;
        end else begin
            if (flushE) exp_q = '{default: 0};
            else if (!stallE) exp_q = validD ? cur : '{default: 0};
            if (regwriteW && rdW != 5'd0) rf[rdW] = resultW;
        end
        @(posedge clk);
        #1;
        cmp_all(tag);
    endtask

    function automatic logic [31:0] rand_instr();
        logic [31:0] ins;
        int          k;
        if ($urandom_range(0, 9) == 0) return $urandom;
        k = $urandom_range(0, NT - 1);
        ins = tbl[k].match | ($urandom & ~tbl[k].mask);
        if ($urandom_range(0, 1) == 1) begin
            ins[11:7]  = 5'($urandom_range(0, 7));
            ins[19:15] = 5'($urandom_range(0, 7));
            ins[24:20] = 5'($urandom_range(0, 7));
        end
        return ins;
    endfunction

    initial begin
        exp_q = '{default: 0};
        for (int i = 0; i < 32; i++) rf[i] = 32'd0;

        rst = 1'b1;
        set_in(1, 32'h00028333, 1, 5, 32'h11111111, 1, 0, 32'h40);
        step("reset");
        rst = 1'b0;
        set_in(1, 32'h00028333, 0, 0, 0, 0, 0, 32'h44);
        step("first");

        set_in(0, 32'h0, 1, 5, 32'hDEADBEEF, 0, 0, 32'h48);
        step("wr_x5");
        set_in(1, 32'h00028333, 0, 0, 0, 0, 0, 32'h4C);
        step("add_x6");
        chk("wr_rd.rd1", rd1E, 32'hDEADBEEF);
        chk("wr_rd.alu", aluselE, 4'd0);
        chk("wr_rd.wr", regwriteE, 1'b1);

        set_in(1, 32'hFFF38413, 1, 7, 32'h12345678, 0, 0, 32'h50);
        step("bypass");
        chk("bypass.rd1", rd1E, 32'h12345678);
        chk("bypass.imm", imm_exE, 32'hFFFFFFFF);

        set_in(1, 32'h0000A483, 0, 0, 0, 0, 0, 32'h54);
        step("lw_x9");
        set_in(1, 32'h40248533, 0, 0, 0, 0, 1, 32'h58);
        #1;
        chk("loaduse.flag", loaduse_hazard, 1'b1);
        step("ld_flush");
        chk("ld_flush.zero", {validE, regwriteE, rdE, rd1E, pcE}, '0);

        set_in(1, 32'h002088B3, 0, 0, 0, 0, 0, 32'h5C);
        step("rv32e");
        chk("rv32e.e", {b_validE, b_illegalE, b_regwriteE}, 3'b110);

        set_in(1, 32'h001000EF, 0, 0, 0, 0, 0, 32'h100);
        step("jal");
        for (int i = 0; i < 3; i++) begin
            set_in(1, rand_instr(), 1, 3, 32'hA5A50003, 1, 0, 32'h104);
            step("stall");
            chk("stall.hold", {pcE, imm_exE, jumpE},
                {32'h100, 32'h800, 1'b1});
        end
        set_in(1, 32'h00018233, 0, 0, 0, 1, 1, 32'h108);
        step("st_fl");
        chk("st_fl.valid", validE, 1'b0);
        set_in(1, 32'h00018233, 0, 0, 0, 0, 0, 32'h108);
        step("rd_x3");
        chk("rd_x3.rd1", rd1E, 32'hA5A50003);

        set_in(1, 32'h00208463, 0, 0, 0, 0, 0, 32'h10C);
        step("beq");
        chk("beq.branch", branchE, 1'b1);
        rst = 1'b1;
        set_in(1, rand_instr(), 1, 9, 32'h99, 1, 1, 32'h110);
        step("mid_rst");
        rst = 1'b0;
        set_in(1, 32'h00028333, 0, 0, 0, 0, 0, 32'h114);
        step("after_rst");
        chk("after_rst.x5", rd1E, 32'd0);

        for (int n = 0; n < 3000; n++) begin
            rst = ($urandom_range(0, 59) == 0);
            set_in($urandom_range(0, 7) != 0, rand_instr(),
                   $urandom_range(0, 1) == 1, 5'($urandom_range(0, 31)),
                   $urandom, $urandom_range(0, 5) == 0,
                   $urandom_range(0, 7) == 0, $urandom & 32'hFFFFFFFC);
            step("rand");
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
